// File: rtl/eci_dcs_tx_serializer_if.sv
// Packet channels into the DCS TX serializer and the word-serial stream out of it.
// Signal names follow the CDC side, so *_o are inputs to the serializer and *_i outputs.
interface eci_dcs_tx_serializer_if #(
   parameter int unsigned ECI_WORD_WIDTH        = 64,
   parameter int unsigned ECI_PACKET_SIZE       = 17,
   parameter int unsigned ECI_PACKET_SIZE_WIDTH = 5
);
   logic [ECI_WORD_WIDTH-1:0]                       rsp_wod_hdr_o;
   logic [ECI_PACKET_SIZE_WIDTH-1:0]                rsp_wod_pkt_size_o;
   logic [3:0]                                      rsp_wod_pkt_vc_o;
   logic                                            rsp_wod_pkt_valid_o;
   logic                                            rsp_wod_pkt_ready_i;

   logic [ECI_PACKET_SIZE-1:0][ECI_WORD_WIDTH-1:0]  rsp_wd_pkt_o;
   logic [ECI_PACKET_SIZE_WIDTH-1:0]                rsp_wd_pkt_size_o;
   logic [3:0]                                      rsp_wd_pkt_vc_o;
   logic                                            rsp_wd_pkt_valid_o;
   logic                                            rsp_wd_pkt_ready_i;

   logic [ECI_WORD_WIDTH-1:0]                       fwd_wod_hdr_o;
   logic [ECI_PACKET_SIZE_WIDTH-1:0]                fwd_wod_pkt_size_o;
   logic [3:0]                                      fwd_wod_pkt_vc_o;
   logic                                            fwd_wod_pkt_valid_o;
   logic                                            fwd_wod_pkt_ready_i;

   logic [ECI_WORD_WIDTH-1:0]                       tx_word_o;
   logic [3:0]                                      tx_vc_o;
   logic                                            tx_first_o;
   logic                                            tx_last_o;
   logic                                            tx_valid_o;
   logic                                            tx_ready_i;

   // Packet sources and stream sink.
   modport master (
      output rsp_wod_hdr_o, rsp_wod_pkt_size_o, rsp_wod_pkt_vc_o, rsp_wod_pkt_valid_o,
      input  rsp_wod_pkt_ready_i,
      output rsp_wd_pkt_o, rsp_wd_pkt_size_o, rsp_wd_pkt_vc_o, rsp_wd_pkt_valid_o,
      input  rsp_wd_pkt_ready_i,
      output fwd_wod_hdr_o, fwd_wod_pkt_size_o, fwd_wod_pkt_vc_o, fwd_wod_pkt_valid_o,
      input  fwd_wod_pkt_ready_i,
      input  tx_word_o, tx_vc_o, tx_first_o, tx_last_o, tx_valid_o,
      output tx_ready_i
   );

   // The serializer.
   modport slave (
      input  rsp_wod_hdr_o, rsp_wod_pkt_size_o, rsp_wod_pkt_vc_o, rsp_wod_pkt_valid_o,
      output rsp_wod_pkt_ready_i,
      input  rsp_wd_pkt_o, rsp_wd_pkt_size_o, rsp_wd_pkt_vc_o, rsp_wd_pkt_valid_o,
      output rsp_wd_pkt_ready_i,
      input  fwd_wod_hdr_o, fwd_wod_pkt_size_o, fwd_wod_pkt_vc_o, fwd_wod_pkt_valid_o,
      output fwd_wod_pkt_ready_i,
      output tx_word_o, tx_vc_o, tx_first_o, tx_last_o, tx_valid_o,
      input  tx_ready_i
   );
endinterface

// File: rtl/eci_dcs_tx_serializer.sv
// Merges the rsp_wod, rsp_wd and fwd_wod packet channels into one word-serial ECI stream.
// Round-robin grant held for a whole packet; back-to-back packets without a bubble.
module eci_dcs_tx_serializer #(
   parameter int unsigned ECI_WORD_WIDTH        = 64,
   parameter int unsigned ECI_PACKET_SIZE       = 17,
   parameter int unsigned ECI_PACKET_SIZE_WIDTH = 5
) (
   input logic                   eci_clk,
   input logic                   eci_reset_n,
   eci_dcs_tx_serializer_if.slave dcs
);
   localparam int unsigned PSW = ECI_PACKET_SIZE_WIDTH;
   localparam logic [PSW-1:0] MaxSize = PSW'(ECI_PACKET_SIZE);
   localparam logic [PSW-1:0] OneWord = PSW'(1);

   typedef logic [ECI_PACKET_SIZE-1:0][ECI_WORD_WIDTH-1:0] pkt_t;
   typedef enum logic {StIdle, StSend} state_e;

   state_e                    state_q;
   pkt_t                      pkt_q;
   logic [PSW-1:0]            idx_q, size_q;
   logic [1:0]                rr_q;
   logic                      armed_q;
   logic                      tx_valid_q, tx_first_q, tx_last_q;
   logic [ECI_WORD_WIDTH-1:0] tx_word_q;
   logic [3:0]                tx_vc_q;

   logic [2:0]                vld;
   logic [1:0]                gnt, cand;
   logic                      any_vld, xfer, can_accept, accept;
   logic [2:0]                ready;
   logic [PSW-1:0]            idx_nxt, new_size;
   pkt_t                      new_pkt;
   logic [3:0]                new_vc;

   // Size fields of the without-data channels carry no meaning here.
   logic unused_wod_sizes;
   assign unused_wod_sizes = ^{dcs.rsp_wod_pkt_size_o, dcs.fwd_wod_pkt_size_o};

   assign vld = {dcs.fwd_wod_pkt_valid_o, dcs.rsp_wd_pkt_valid_o, dcs.rsp_wod_pkt_valid_o};

   // Round-robin search starting at the channel after the last grant.
   always_comb begin
      gnt     = 2'd0;
      any_vld = 1'b0;
      cand    = rr_q;
      for (int k = 0; k < 3; k++) begin
         cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
         if (!any_vld && vld[cand]) begin
            any_vld = 1'b1;
            gnt     = cand;
         end
      end
   end

   // armed_q keeps all readies low until one clock after reset release.
   assign xfer       = tx_valid_q & dcs.tx_ready_i;
   assign can_accept = armed_q & ((state_q == StIdle) | (xfer & tx_last_q));
   assign accept     = can_accept & any_vld;
   assign ready      = accept ? (3'b001 << gnt) : 3'b000;
   assign idx_nxt    = idx_q + OneWord;

   // Select the winning channel's packet and derive its effective length.
   always_comb begin
      new_pkt  = '0;
      new_size = OneWord;
      new_vc   = '0;
      case (gnt)
         2'd0: begin
            new_pkt[0] = dcs.rsp_wod_hdr_o;
            new_vc     = dcs.rsp_wod_pkt_vc_o;
         end
         2'd1: begin
            new_pkt = dcs.rsp_wd_pkt_o;
            new_vc  = dcs.rsp_wd_pkt_vc_o;
            if (dcs.rsp_wd_pkt_size_o == '0) begin
               new_size = OneWord;
            end else if (dcs.rsp_wd_pkt_size_o > MaxSize) begin
               new_size = MaxSize;
            end else begin
               new_size = dcs.rsp_wd_pkt_size_o;
            end
         end
         default: begin
            new_pkt[0] = dcs.fwd_wod_hdr_o;
            new_vc     = dcs.fwd_wod_pkt_vc_o;
         end
      endcase
   end

   // Packet FSM with registered stream outputs.
   always_ff @(posedge eci_clk or negedge eci_reset_n) begin
      if (!eci_reset_n) begin
         state_q    <= StIdle;
         pkt_q      <= '0;
         idx_q      <= '0;
         size_q     <= '0;
         rr_q       <= 2'd2;
         armed_q    <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_first_q <= 1'b0;
         tx_last_q  <= 1'b0;
         tx_word_q  <= '0;
         tx_vc_q    <= '0;
      end else begin
         armed_q <= 1'b1;
         if (accept) begin
            state_q    <= StSend;
            rr_q       <= gnt;
            pkt_q      <= new_pkt;
            size_q     <= new_size;
            idx_q      <= '0;
            tx_valid_q <= 1'b1;
            tx_word_q  <= new_pkt[0];
            tx_vc_q    <= new_vc;
            tx_first_q <= 1'b1;
            tx_last_q  <= (new_size == OneWord);
         end else if (xfer) begin
            if (tx_last_q) begin
               state_q    <= StIdle;
               tx_valid_q <= 1'b0;
            end else begin
               idx_q      <= idx_nxt;
               tx_word_q  <= pkt_q[idx_nxt];
               tx_first_q <= 1'b0;
               tx_last_q  <= (idx_nxt == size_q - OneWord);
            end
         end
      end
   end

   assign dcs.rsp_wod_pkt_ready_i = ready[0];
   assign dcs.rsp_wd_pkt_ready_i  = ready[1];
   assign dcs.fwd_wod_pkt_ready_i = ready[2];
   assign dcs.tx_word_o           = tx_word_q;
   assign dcs.tx_vc_o             = tx_vc_q;
   assign dcs.tx_first_o          = tx_first_q;
   assign dcs.tx_last_o           = tx_last_q;
   assign dcs.tx_valid_o          = tx_valid_q;

endmodule

// File: tb/tb_eci_dcs_tx_serializer.sv
// Directed bench for the DCS TX serializer: single-packet vector table plus
// arbitration, stall and mid-packet reset sequences.
module tb_eci_dcs_tx_serializer;
   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   eci_dcs_tx_serializer_if #(
      .ECI_WORD_WIDTH(64), .ECI_PACKET_SIZE(17), .ECI_PACKET_SIZE_WIDTH(5)
   ) bus ();

   eci_dcs_tx_serializer #(
      .ECI_WORD_WIDTH(64), .ECI_PACKET_SIZE(17), .ECI_PACKET_SIZE_WIDTH(5)
   ) dut (
      .eci_clk    (clk),
      .eci_reset_n(rst_n),
      .dcs        (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   typedef struct {
      int          ch;
      logic [4:0]  sz;
      logic [3:0]  vc;
      logic [63:0] base;
      int          exp_n;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   function automatic logic rdy(input int ch);
      case (ch)
         0:       return bus.rsp_wod_pkt_ready_i;
         1:       return bus.rsp_wd_pkt_ready_i;
         default: return bus.fwd_wod_pkt_ready_i;
      endcase
   endfunction

   task automatic drive_chan(input int ch, input logic [4:0] sz, input logic [3:0] vc,
                             input logic [63:0] base, input logic v);
      case (ch)
         0: begin
            bus.rsp_wod_hdr_o = base; bus.rsp_wod_pkt_size_o = sz;
            bus.rsp_wod_pkt_vc_o = vc; bus.rsp_wod_pkt_valid_o = v;
         end
         1: begin
            for (int i = 0; i < 17; i++) bus.rsp_wd_pkt_o[i] = base + 64'(i);
            bus.rsp_wd_pkt_size_o = sz; bus.rsp_wd_pkt_vc_o = vc; bus.rsp_wd_pkt_valid_o = v;
         end
         default: begin
            bus.fwd_wod_hdr_o = base; bus.fwd_wod_pkt_size_o = sz;
            bus.fwd_wod_pkt_vc_o = vc; bus.fwd_wod_pkt_valid_o = v;
         end
      endcase
   endtask

   // Sends one packet on one channel and checks every word. Entered at a negedge.
   task automatic run_pkt(input string nm, input int ch, input logic [4:0] sz,
                          input logic [3:0] vc, input logic [63:0] base, input int exp_n,
                          input bit stall);
      int          got = 0, rdy_n = 0, other_n = 0;
      bit          acc, pstall = 0;
      logic [63:0] pw;
      logic [3:0]  pvc;
      logic        pf, pl;
      drive_chan(ch, sz, vc, base, 1'b1);
      bus.tx_ready_i = 1'b1;
      for (int cyc = 0; cyc < 400 && got < exp_n; cyc++) begin
         #1;
         acc = rdy(ch);
         if (acc) rdy_n++;
         for (int c = 0; c < 3; c++) if (c != ch && rdy(c)) other_n++;
         if (pstall) begin
            chk({nm, " stall_valid"}, 64'(bus.tx_valid_o), 64'd1);
            chk({nm, " stall_word"}, bus.tx_word_o, pw);
            chk({nm, " stall_vc"}, 64'(bus.tx_vc_o), 64'(pvc));
            chk({nm, " stall_first"}, 64'(bus.tx_first_o), 64'(pf));
            chk({nm, " stall_last"}, 64'(bus.tx_last_o), 64'(pl));
         end
         pstall = bus.tx_valid_o && !bus.tx_ready_i;
         pw = bus.tx_word_o; pvc = bus.tx_vc_o; pf = bus.tx_first_o; pl = bus.tx_last_o;
         if (bus.tx_valid_o && bus.tx_ready_i) begin
            chk({nm, " word"}, bus.tx_word_o, (ch == 1) ? base + 64'(got) : base);
            chk({nm, " vc"}, 64'(bus.tx_vc_o), 64'(vc));
            chk({nm, " first"}, 64'(bus.tx_first_o), 64'(got == 0));
            chk({nm, " last"}, 64'(bus.tx_last_o), 64'(got == exp_n - 1));
            got++;
         end
         @(posedge clk); @(negedge clk);
         if (acc) drive_chan(ch, sz, vc, base, 1'b0);
         if (stall) bus.tx_ready_i = 1'($urandom_range(0, 1));
      end
      bus.tx_ready_i = 1'b1;
      drive_chan(ch, sz, vc, base, 1'b0);
      chk({nm, " word_count"}, 64'(got), 64'(exp_n));
      chk({nm, " ready_pulses"}, 64'(rdy_n), 64'd1);
      chk({nm, " other_ready"}, 64'(other_n), 64'd0);
      #1;
      chk({nm, " idle_after"}, 64'(bus.tx_valid_o), 64'd0);
   endtask

   vec_t vecs[7];

   initial begin
      int          ord[4];
      int          wcyc[4];
      logic [63:0] wds[4];
      int          n_ord, n_w, acc_ch, nrdy, got;
      bit          acc;

      vecs[0] = '{0, 5'd3,  4'd1, 64'h00A0, 1};
      vecs[1] = '{2, 5'd9,  4'd2, 64'h00B0, 1};
      vecs[2] = '{1, 5'd0,  4'd3, 64'h0200, 1};
      vecs[3] = '{1, 5'd31, 4'd4, 64'h0300, 17};
      vecs[4] = '{1, 5'd17, 4'd5, 64'h0100, 17};
      vecs[5] = '{1, 5'd4,  4'd6, 64'h0400, 4};
      vecs[6] = '{0, 5'd0,  4'd7, 64'h00C0, 1};

      // Reset state with all three channels already valid.
      rst_n = 1'b0;
      bus.tx_ready_i = 1'b1;
      drive_chan(0, 5'd1, 4'd1, 64'h00A1, 1'b1);
      drive_chan(1, 5'd1, 4'd2, 64'h0B10, 1'b1);
      drive_chan(2, 5'd1, 4'd3, 64'h00C1, 1'b1);
      repeat (2) @(negedge clk);
      #1;
      chk("rst tx_valid", 64'(bus.tx_valid_o), 64'd0);
      chk("rst tx_first", 64'(bus.tx_first_o), 64'd0);
      chk("rst tx_last", 64'(bus.tx_last_o), 64'd0);
      chk("rst tx_word", bus.tx_word_o, 64'd0);
      chk("rst tx_vc", 64'(bus.tx_vc_o), 64'd0);
      chk("rst readies", 64'({bus.fwd_wod_pkt_ready_i, bus.rsp_wd_pkt_ready_i,
                              bus.rsp_wod_pkt_ready_i}), 64'd0);

      // Round-robin from reset: 0,1,2 back-to-back.
      @(negedge clk);
      rst_n = 1'b1;
      n_ord = 0; n_w = 0;
      for (int i = 0; i < 4; i++) begin ord[i] = -1; wcyc[i] = -1; wds[i] = '1; end
      for (int cyc = 0; cyc < 10; cyc++) begin
         #1;
         acc_ch = -1; nrdy = 0;
         for (int c = 0; c < 3; c++) if (rdy(c)) begin acc_ch = c; nrdy++; end
         if (nrdy > 1) chk("rr onehot_ready", 64'(nrdy), 64'd1);
         if (acc_ch >= 0 && n_ord < 4) begin ord[n_ord] = acc_ch; n_ord++; end
         if (bus.tx_valid_o && bus.tx_ready_i && n_w < 4) begin
            wds[n_w] = bus.tx_word_o; wcyc[n_w] = cyc; n_w++;
         end
         @(posedge clk); @(negedge clk);
         if (acc_ch >= 0) drive_chan(acc_ch, 5'd1, 4'(acc_ch + 1), 64'd0, 1'b0);
      end
      chk("rr grant_count", 64'(n_ord), 64'd3);
      chk("rr grant0", 64'(ord[0]), 64'd0);
      chk("rr grant1", 64'(ord[1]), 64'd1);
      chk("rr grant2", 64'(ord[2]), 64'd2);
      chk("rr word_count", 64'(n_w), 64'd3);
      chk("rr word0", wds[0], 64'h00A1);
      chk("rr word1", wds[1], 64'h0B10);
      chk("rr word2", wds[2], 64'h00C1);
      chk("rr no_bubble01", 64'(wcyc[1] - wcyc[0]), 64'd1);
      chk("rr no_bubble12", 64'(wcyc[2] - wcyc[1]), 64'd1);

      // Table of single packets.
      for (int v = 0; v < 7; v++) begin
         run_pkt($sformatf("vec%0d", v), vecs[v].ch, vecs[v].sz, vecs[v].vc, vecs[v].base,
                 vecs[v].exp_n, 1'b0);
         @(negedge clk);
      end

      // Random backpressure over a full packet.
      run_pkt("stall", 1, 5'd17, 4'd6, 64'h0600, 17, 1'b1);
      @(negedge clk);

      // Reset in the middle of a 17-word packet.
      drive_chan(1, 5'd17, 4'd5, 64'h0500, 1'b1);
      got = 0;
      for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
         #1;
         acc = bus.rsp_wd_pkt_ready_i;
         if (bus.tx_valid_o && bus.tx_ready_i) got++;
         @(posedge clk); @(negedge clk);
         if (acc) drive_chan(1, 5'd17, 4'd5, 64'h0500, 1'b0);
      end
      chk("midrst words_before", 64'(got), 64'd8);
      rst_n = 1'b0;
      #1;
      chk("midrst tx_valid", 64'(bus.tx_valid_o), 64'd0);
      chk("midrst tx_word", bus.tx_word_o, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_pkt("post_rst_fwd", 2, 5'd2, 4'd9, 64'h0D00, 1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/eci_dcs_tx_serializer.md
ECI_DCS_TX_SERIALIZER -- requirements
Module: eci_dcs_tx_serializer

Interface
REQ-001 Parameter: ECI_WORD_WIDTH, default 64, bit width of one ECI word.
REQ-002 Parameter: ECI_PACKET_SIZE, default 17, maximum number of words in a packet.
REQ-003 Parameter: ECI_PACKET_SIZE_WIDTH, default 5, width of the packet-size fields.
REQ-004 Clocking and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-005 eci_clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 eci_reset_n  in  1  asynchronous active-low reset.
REQ-007 rsp_wod_hdr_o / rsp_wod_pkt_size_o / rsp_wod_pkt_vc_o / rsp_wod_pkt_valid_o  in  64/5/4/1  response-without-data channel from the DCS output CDC.
REQ-008 rsp_wod_pkt_ready_i  out  1  accept for the rsp_wod channel.
REQ-009 rsp_wd_pkt_o / rsp_wd_pkt_size_o / rsp_wd_pkt_vc_o / rsp_wd_pkt_valid_o  in  17x64/5/4/1  response-with-data channel; word 0 is the header.
REQ-010 rsp_wd_pkt_ready_i  out  1  accept for the rsp_wd channel.
REQ-011 fwd_wod_hdr_o / fwd_wod_pkt_size_o / fwd_wod_pkt_vc_o / fwd_wod_pkt_valid_o  in  64/5/4/1  forward-without-data channel.
REQ-012 fwd_wod_pkt_ready_i  out  1  accept for the fwd_wod channel.
REQ-013 tx_word_o  out  64  serialized ECI word.
REQ-014 tx_vc_o  out  4  VC of the current packet.
REQ-015 tx_first_o / tx_last_o  out  1/1  first and last word markers.
REQ-016 tx_valid_o  out  1  word valid.
REQ-017 tx_ready_i  in  1  downstream accept.

Function
REQ-018 The block SHALL merge the three packet channels into one word-serial stream; a word transfers when tx_valid_o and tx_ready_i are both high.
REQ-019 Arbitration SHALL be round-robin across the order rsp_wod(0), rsp_wd(1), fwd_wod(2), starting the search after the last granted channel; after reset the search starts at channel 0.
REQ-020 The FSM SHALL have two states, IDLE and SEND; the grant SHALL be held for a whole packet, with no interleaving of words from different packets.
REQ-021 In IDLE with any valid input, the block SHALL assert ready for exactly the winning channel for one cycle, capture that channel's data, size and vc into a packet register, and enter SEND.
REQ-022 Latency SHALL be one cycle: the input handshake in cycle N gives tx_valid_o=1 with word 0 in cycle N+1.
REQ-023 In SEND, a word index counter (5 bit) SHALL select word idx of the packet register and advance only on a word transfer.
REQ-024 tx_first_o SHALL equal (idx==0), and tx_last_o SHALL equal (idx==eff_size-1).
REQ-025 Effective size: a wod channel SHALL always be sent as 1 word regardless of its size field; for rsp_wd, size 0 SHALL be treated as 1 and size greater than 17 SHALL be clamped to 17.
REQ-026 On transfer of the last word, if another input is valid, the block SHALL capture it in the same cycle (back-to-back, no bubble) and stay in SEND with idx=0; otherwise it SHALL return to IDLE with tx_valid_o=0.
REQ-027 The ready outputs SHALL be asserted only in IDLE or on the cycle of a last-word transfer, and at most one SHALL be high at a time.
REQ-028 While tx_ready_i=0, tx_word_o, tx_vc_o, tx_first_o and tx_last_o SHALL hold stable.
REQ-029 An input whose valid is low SHALL never be granted; arbitration SHALL be evaluated combinationally from the current valids.

Reset
REQ-030 While eci_reset_n=0, the FSM SHALL be in IDLE, idx=0, RR pointer=2 (next search starts at channel 0), the packet register cleared, tx_valid_o=0, tx_first_o=0, tx_last_o=0, tx_word_o=0, tx_vc_o=0, and all ready outputs 0.
REQ-031 Reset asserted mid-packet SHALL abandon the packet; no further words are emitted, and no input is accepted until one clock after deassertion.

Verification
REQ-032 rsp_wd size 17, vc 5, data words 0x100+i, tx_ready_i=1 -> 17 consecutive words 0x100..0x110, vc 5, first on word 0, last on word 16, rsp_wd_pkt_ready_i pulsed once.
REQ-033 All three valid from reset with 1-word packets, tx_ready_i=1 -> grant order rsp_wod, rsp_wd, fwd_wod, emitted back-to-back in 3 consecutive cycles with no bubble.
REQ-034 fwd_wod size field 9 -> exactly one word, with first=last=1.
REQ-035 rsp_wd size 0 -> 1 word; rsp_wd size 31 -> 17 words.
REQ-036 tx_ready_i toggled randomly during a 17-word packet -> outputs stable while stalled; words in order; none duplicated or lost.
REQ-037 eci_reset_n pulsed low at word 8 of 17 -> tx_valid_o=0 immediately; a subsequent fwd_wod packet is granted first (channel 0 idle) and sent intact.
